// File: rtl/movimiento_pkg.sv
// Shared types and default parameters for the sliding-tile board engine.
package movimiento_pkg;

    localparam int unsigned N_DEF         = 4;
    localparam int unsigned EXP_W_DEF     = 4;
    localparam int unsigned SCORE_W_DEF   = 24;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        ARRIBA = 2'b00,
        ABAJO  = 2'b01,
        IZQ    = 2'b10,
        DER    = 2'b11
    } dir_t;

    typedef logic [2:0] estado_t;

    localparam estado_t IDLE  = 3'd0;
    localparam estado_t CLEAR = 3'd1;
    localparam estado_t SPAWN = 3'd2;
    localparam estado_t WAIT  = 3'd3;
    localparam estado_t SHIFT = 3'd4;
    localparam estado_t CHECK = 3'd5;
    localparam estado_t EVAL  = 3'd6;
    localparam estado_t OVER  = 3'd7;

endpackage

// File: rtl/motor_movimiento_if.sv
// Move request handshake between the button front end and the board engine.
interface motor_movimiento_if;
    import movimiento_pkg::*;

    logic move_valid;
    dir_t move_dir;
    logic move_ready;

    modport master (output move_valid, output move_dir, input move_ready);
    modport slave  (input move_valid, input move_dir, output move_ready);

endinterface

// File: rtl/line_merge.sv
// Compress and merge one line of exponents toward index 0.
module line_merge
    import movimiento_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned EXP_W   = EXP_W_DEF,
    parameter int unsigned SCORE_W = SCORE_W_DEF
) (
    input  logic [N*EXP_W-1:0] line_in,
    output logic [N*EXP_W-1:0] line_out_c,
    output logic [SCORE_W-1:0] score_inc_c,
    output logic               changed_c
);

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic [EXP_W-1:0] comp   [N+1];
    logic [EXP_W-1:0] merged [N];
    int               cnt;
    int               j;
    logic             skip;

    // comp[N] stays zero so the last tile never finds a partner
    always_comb begin
        for (int k = 0; k <= N; k++) comp[k] = '0;
        for (int k = 0; k < N; k++) merged[k] = '0;
        cnt         = 0;
        j           = 0;
        skip        = 1'b0;
        score_inc_c = '0;
        for (int k = 0; k < N; k++) begin
            if (line_in[k*EXP_W +: EXP_W] != '0) begin
                comp[cnt] = line_in[k*EXP_W +: EXP_W];
                cnt       = cnt + 1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[k] != '0) begin
                if (comp[k] == comp[k+1] && comp[k] != EXP_MAX) begin
                    merged[j]   = comp[k] + EXP_W'(1);
                    score_inc_c = score_inc_c + (SCORE_W'(1) << (comp[k] + EXP_W'(1)));
                    skip        = 1'b1;
                end else begin
                    merged[j] = comp[k];
                end
                j = j + 1;
            end
        end
        for (int k = 0; k < N; k++) line_out_c[k*EXP_W +: EXP_W] = merged[k];
        changed_c = (line_out_c != line_in);
    end

endmodule

// File: rtl/motor_movimiento.sv
// N x N sliding-tile board engine: one line per SHIFT cycle, LFSR tile spawn, score and win/lose.
module motor_movimiento
    import movimiento_pkg::*;
#(
    parameter int unsigned N         = N_DEF,
    parameter int unsigned EXP_W     = EXP_W_DEF,
    parameter int unsigned SCORE_W   = SCORE_W_DEF,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W-1:0]       meta_exp,
    motor_movimiento_if.slave      mv,
    input  logic                   carga_valid,
    input  logic [N*N*EXP_W-1:0]   carga_tablero,
    output logic [N*N*EXP_W-1:0]   tablero,
    output logic [SCORE_W-1:0]     score,
    output logic                   busy,
    output logic                   gano,
    output logic                   perdio
);

    localparam int unsigned BW     = N*N*EXP_W;
    localparam int unsigned PTR_W  = $clog2(N*N);
    localparam int unsigned LINE_W = (N > 1) ? $clog2(N) : 1;

    estado_t             state_q, state_n;
    logic [BW-1:0]       board_q, board_n;
    logic [SCORE_W-1:0]  score_q, score_n;
    logic                gano_q, gano_n, perdio_q, perdio_n;
    logic                ready_q, ready_n, busy_q, busy_n;
    logic [EXP_W-1:0]    meta_q, meta_n;
    dir_t                dir_q, dir_n;
    logic [LINE_W-1:0]   line_q, line_n;
    logic                changed_q, changed_n;
    logic [1:0]          spawn_q, spawn_n;
    logic [PTR_W-1:0]    ptr_q, ptr_n, ptr_ini;
    logic [15:0]         lfsr_q, lfsr_n;

    logic [N*EXP_W-1:0]  line_in, line_out;
    logic [SCORE_W-1:0]  score_inc;
    logic                line_chg;
    logic [SCORE_W:0]    score_sum;
    logic                hay_vacio, hay_par, hay_meta;

    // Board cell holding the k-th tile of a line, read in the move direction
    function automatic int cell_idx(input dir_t d, input int line, input int k);
        int idx;
        idx = 0;
        case (d)
            ARRIBA:  idx = k*N + line;
            ABAJO:   idx = (N-1-k)*N + line;
            IZQ:     idx = line*N + k;
            default: idx = line*N + (N-1-k);
        endcase
        return idx;
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++)
            line_in[k*EXP_W +: EXP_W] = board_q[cell_idx(dir_q, int'(line_q), k)*EXP_W +: EXP_W];
    end

    line_merge #(.N(N), .EXP_W(EXP_W), .SCORE_W(SCORE_W)) u_line_merge (
        .line_in     (line_in),
        .line_out_c  (line_out),
        .score_inc_c (score_inc),
        .changed_c   (line_chg)
    );

    always_comb begin
        state_n   = state_q;
        board_n   = board_q;
        score_n   = score_q;
        gano_n    = gano_q;
        perdio_n  = perdio_q;
        meta_n    = meta_q;
        dir_n     = dir_q;
        line_n    = line_q;
        changed_n = changed_q;
        spawn_n   = spawn_q;
        ptr_n     = ptr_q;
        lfsr_n    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        ptr_ini   = PTR_W'(lfsr_q % 16'(N*N));
        score_sum = {1'b0, score_q} + {1'b0, score_inc};
        hay_vacio = 1'b0;
        hay_par   = 1'b0;
        hay_meta  = 1'b0;

        for (int i = 0; i < N*N; i++) begin
            if (board_q[i*EXP_W +: EXP_W] == '0)    hay_vacio = 1'b1;
            if (board_q[i*EXP_W +: EXP_W] >= meta_q) hay_meta  = 1'b1;
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N-1; c++)
                if (board_q[(r*N+c)*EXP_W +: EXP_W] == board_q[(r*N+c+1)*EXP_W +: EXP_W]) hay_par = 1'b1;
        for (int r = 0; r < N-1; r++)
            for (int c = 0; c < N; c++)
                if (board_q[(r*N+c)*EXP_W +: EXP_W] == board_q[((r+1)*N+c)*EXP_W +: EXP_W]) hay_par = 1'b1;

        case (state_q)
            IDLE: ;
            CLEAR: begin
                board_n  = '0;
                score_n  = '0;
                gano_n   = 1'b0;
                perdio_n = 1'b0;
                spawn_n  = 2'd2;
                ptr_n    = ptr_ini;
                state_n  = SPAWN;
            end
            SPAWN: begin
                if (board_q[ptr_q*EXP_W +: EXP_W] == '0) begin
                    board_n[ptr_q*EXP_W +: EXP_W] = (lfsr_q[15:13] == 3'b111) ? EXP_W'(2) : EXP_W'(1);
                    if (spawn_q == 2'd1) begin
                        spawn_n = 2'd0;
                        state_n = EVAL;
                    end else begin
                        spawn_n = spawn_q - 2'd1;
                        ptr_n   = ptr_ini;
                    end
                end else begin
                    ptr_n = (ptr_q == PTR_W'(N*N-1)) ? '0 : ptr_q + PTR_W'(1);
                end
            end
            WAIT: begin
                if (mv.move_valid) begin
                    dir_n     = mv.move_dir;
                    line_n    = '0;
                    changed_n = 1'b0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                for (int k = 0; k < N; k++)
                    board_n[cell_idx(dir_q, int'(line_q), k)*EXP_W +: EXP_W] = line_out[k*EXP_W +: EXP_W];
                score_n   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                changed_n = changed_q | line_chg;
                if (line_q == LINE_W'(N-1)) state_n = CHECK;
                else                        line_n  = line_q + LINE_W'(1);
            end
            CHECK: begin
                if (changed_q) begin
                    spawn_n = 2'd1;
                    ptr_n   = ptr_ini;
                    state_n = SPAWN;
                end else begin
                    state_n = WAIT;
                end
            end
            EVAL: begin
                gano_n   = hay_meta && (meta_q != '0);
                perdio_n = !hay_vacio && !hay_par;
                state_n  = (gano_n || perdio_n) ? OVER : WAIT;
            end
            OVER: ;
            default: state_n = IDLE;
        endcase

        // start beats board load, which beats a pending move
        if (carga_valid && (state_q == IDLE || state_q == WAIT || state_q == OVER)) begin
            board_n = carga_tablero;
            state_n = EVAL;
        end
        if (start) begin
            board_n  = '0;
            score_n  = '0;
            gano_n   = 1'b0;
            perdio_n = 1'b0;
            meta_n   = meta_exp;
            state_n  = CLEAR;
        end

        ready_n = (state_n == WAIT);
        busy_n  = (state_n == CLEAR) || (state_n == SPAWN) || (state_n == SHIFT) ||
                  (state_n == CHECK) || (state_n == EVAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            board_q   <= '0;
            score_q   <= '0;
            gano_q    <= 1'b0;
            perdio_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            meta_q    <= '0;
            dir_q     <= ARRIBA;
            line_q    <= '0;
            changed_q <= 1'b0;
            spawn_q   <= 2'd0;
            ptr_q     <= '0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            state_q   <= state_n;
            board_q   <= board_n;
            score_q   <= score_n;
            gano_q    <= gano_n;
            perdio_q  <= perdio_n;
            ready_q   <= ready_n;
            busy_q    <= busy_n;
            meta_q    <= meta_n;
            dir_q     <= dir_n;
            line_q    <= line_n;
            changed_q <= changed_n;
            spawn_q   <= spawn_n;
            ptr_q     <= ptr_n;
            lfsr_q    <= lfsr_n;
        end
    end

    assign tablero       = board_q;
    assign score         = score_q;
    assign busy          = busy_q;
    assign gano          = gano_q;
    assign perdio        = perdio_q;
    assign mv.move_ready = ready_q;

endmodule

// File: tb/tb_motor_movimiento.sv
// Scoreboard bench for motor_movimiento on a 4x4 board.
module tb_motor_movimiento;
    import movimiento_pkg::*;

    localparam int unsigned N       = 4;
    localparam int unsigned EXP_W   = 4;
    localparam int unsigned SCORE_W = 24;
    localparam int unsigned BW      = N*N*EXP_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               carga_valid = 1'b0;
    logic [EXP_W-1:0]   meta_exp = '0;
    logic [BW-1:0]      carga_tablero = '0;
    logic [BW-1:0]      tablero;
    logic [SCORE_W-1:0] score;
    logic               busy, gano, perdio;
    logic [BW-1:0]      cb;

    int vectors = 0;
    int errors  = 0;

    motor_movimiento_if mif();

    motor_movimiento #(.N(N), .EXP_W(EXP_W), .SCORE_W(SCORE_W), .LFSR_SEED(16'hACE1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .meta_exp      (meta_exp),
        .mv            (mif),
        .carga_valid   (carga_valid),
        .carga_tablero (carga_tablero),
        .tablero       (tablero),
        .score         (score),
        .busy          (busy),
        .gano          (gano),
        .perdio        (perdio)
    );

    always #5 clk = ~clk;

    typedef enum {O_BOARD, O_SCORE, O_READY, O_BUSY, O_GANO, O_PERDIO,
                  O_CELL00, O_CELL01, O_NZ_ALL, O_BAD_ALL, O_NZ_TAIL} obs_t;
    typedef struct {
        obs_t          kind;
        string         tag;
        logic [BW-1:0] exp;
    } exp_t;

    exp_t sb[$];

    function automatic logic [EXP_W-1:0] cell_of(input logic [BW-1:0] b, input int idx);
        return b[idx*EXP_W +: EXP_W];
    endfunction

    function automatic logic [BW-1:0] observe(input obs_t k);
        int n;
        n = 0;
        case (k)
            O_BOARD:  return tablero;
            O_SCORE:  return BW'(score);
            O_READY:  return BW'(mif.move_ready);
            O_BUSY:   return BW'(busy);
            O_GANO:   return BW'(gano);
            O_PERDIO: return BW'(perdio);
            O_CELL00: return BW'(cell_of(tablero, 0));
            O_CELL01: return BW'(cell_of(tablero, 1));
            O_NZ_ALL: begin
                for (int i = 0; i < N*N; i++) if (cell_of(tablero, i) != '0) n++;
                return BW'(n);
            end
            O_BAD_ALL: begin
                for (int i = 0; i < N*N; i++) if (cell_of(tablero, i) > EXP_W'(2)) n++;
                return BW'(n);
            end
            default: begin
                for (int i = 2; i < N*N; i++) if (cell_of(tablero, i) != '0) n++;
                return BW'(n);
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_v(input obs_t k, input string tag, input logic [BW-1:0] v);
        exp_t e;
        e.kind = k;
        e.tag  = tag;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input obs_t k, input string tag);
        int n;
        n = 0;
        while (observe(k) == '0 && n < 200) begin
            tick();
            n++;
        end
        if (observe(k) == '0) check({tag, "_timeout"}, '0, BW'(1));
    endtask

    task automatic expect_reset(input string p);
        expect_v(O_BOARD,  {p, "_board"},  '0);
        expect_v(O_SCORE,  {p, "_score"},  '0);
        expect_v(O_READY,  {p, "_ready"},  '0);
        expect_v(O_BUSY,   {p, "_busy"},   '0);
        expect_v(O_GANO,   {p, "_gano"},   '0);
        expect_v(O_PERDIO, {p, "_perdio"}, '0);
    endtask

    function automatic logic [BW-1:0] row0(input logic [EXP_W-1:0] a, input logic [EXP_W-1:0] b,
                                           input logic [EXP_W-1:0] c, input logic [EXP_W-1:0] d);
        logic [BW-1:0] r;
        r = '0;
        r[0*EXP_W +: EXP_W] = a;
        r[1*EXP_W +: EXP_W] = b;
        r[2*EXP_W +: EXP_W] = c;
        r[3*EXP_W +: EXP_W] = d;
        return r;
    endfunction

    task automatic do_start(input logic [EXP_W-1:0] m);
        start    = 1'b1;
        meta_exp = m;
        tick();
        start = 1'b0;
        wait_until(O_READY, "start");
    endtask

    task automatic load(input logic [BW-1:0] b);
        carga_valid   = 1'b1;
        carga_tablero = b;
        tick();
        carga_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_move(input dir_t d);
        mif.move_valid = 1'b1;
        mif.move_dir   = d;
        tick();
        mif.move_valid = 1'b0;
    endtask

    initial begin
        mif.move_valid = 1'b0;
        mif.move_dir   = ARRIBA;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_reset("rst");
        drain();

        do_start(EXP_W'(11));
        expect_v(O_NZ_ALL,  "start_tiles",  BW'(2));
        expect_v(O_BAD_ALL, "start_values", '0);
        expect_v(O_SCORE,   "start_score",  '0);
        expect_v(O_GANO,    "start_gano",   '0);
        expect_v(O_PERDIO,  "start_perdio", '0);
        expect_v(O_READY,   "start_ready",  BW'(1));
        drain();

        load(row0(1, 1, 2, 2));
        do_move(IZQ);
        wait_until(O_READY, "mv_1122");
        expect_v(O_CELL00,  "mv_1122_c0",    BW'(2));
        expect_v(O_CELL01,  "mv_1122_c1",    BW'(3));
        expect_v(O_NZ_TAIL, "mv_1122_spawn", BW'(1));
        expect_v(O_SCORE,   "mv_1122_score", BW'(12));
        drain();

        load(row0(2, 2, 2, 0));
        do_move(IZQ);
        wait_until(O_READY, "mv_222");
        expect_v(O_CELL00,  "mv_222_c0",    BW'(3));
        expect_v(O_CELL01,  "mv_222_c1",    BW'(2));
        expect_v(O_NZ_TAIL, "mv_222_spawn", BW'(1));
        expect_v(O_SCORE,   "mv_222_score", BW'(20));
        drain();

        load(row0(2, 2, 3, 0));
        do_move(IZQ);
        wait_until(O_READY, "mv_223");
        expect_v(O_CELL00,  "mv_223_c0",    BW'(3));
        expect_v(O_CELL01,  "mv_223_c1",    BW'(3));
        expect_v(O_NZ_TAIL, "mv_223_spawn", BW'(1));
        expect_v(O_SCORE,   "mv_223_score", BW'(28));
        drain();

        load(row0(1, 2, 3, 4));
        do_move(ARRIBA);
        repeat (N) tick();
        expect_v(O_READY, "nochg_ready_early", '0);
        drain();
        tick();
        expect_v(O_READY, "nochg_ready_back", BW'(1));
        expect_v(O_BOARD, "nochg_board",      row0(1, 2, 3, 4));
        expect_v(O_SCORE, "nochg_score",      BW'(28));
        drain();

        load(row0(10, 10, 0, 0));
        do_move(IZQ);
        wait_until(O_GANO, "win");
        expect_v(O_CELL00, "win_c0",     BW'(11));
        expect_v(O_GANO,   "win_gano",   BW'(1));
        expect_v(O_PERDIO, "win_perdio", '0);
        expect_v(O_SCORE,  "win_score",  BW'(2076));
        expect_v(O_NZ_ALL, "win_tiles",  BW'(2));
        drain();
        for (int p = 0; p < 3; p++) begin
            mif.move_valid = 1'b1;
            mif.move_dir   = DER;
            tick();
            mif.move_valid = 1'b0;
            tick();
            expect_v(O_READY, "over_ready", '0);
            drain();
        end
        expect_v(O_CELL00, "over_c0",    BW'(11));
        expect_v(O_NZ_ALL, "over_tiles", BW'(2));
        drain();

        cb = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                cb[(r*N+c)*EXP_W +: EXP_W] = ((r + c) % 2 == 0) ? EXP_W'(1) : EXP_W'(2);
        load(cb);
        expect_v(O_BOARD,  "lose_board",  cb);
        expect_v(O_PERDIO, "lose_perdio", BW'(1));
        expect_v(O_GANO,   "lose_gano",   '0);
        expect_v(O_READY,  "lose_ready",  '0);
        drain();

        do_start(EXP_W'(11));
        do_move(ABAJO);
        tick();
        expect_v(O_BUSY, "mid_shift_busy", BW'(1));
        drain();
        rst = 1'b1;
        tick();
        expect_reset("rst_mid");
        drain();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/motor_movimiento.md
# motor_movimiento

Sequential, parametrised N×N sliding-tile (2048-style) board engine; successor of the fixed 4×4 combinational move controller. It holds the board in registers and accepts moves (up/down/left/right) over a valid/ready handshake, processing one line per cycle. After each effective move it spawns a new tile using an internal LFSR, accumulates score, and raises win/lose flags. It sits between the button/debounce front end and the VGA board renderer.

## Interface
- `N`, 4, board side (2..8)
- `EXP_W`, 4, tile field width; tiles stored as exponent, 0 = empty, value = 2^exp
- `SCORE_W`, 24, score width
- `LFSR_SEED`, 16'hACE1, nonzero LFSR reset value
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: new game pulse
- `meta_exp` in EXP_W: win exponent, sampled on `start`
- `move_valid` in 1: move request
- `move_dir` in 2: 00 up, 01 down, 10 left, 11 right
- `move_ready` out 1: move can be accepted
- `carga_valid` in 1: board load request (test/debug)
- `carga_tablero` in N·N·EXP_W: board to load
- `tablero` out N·N·EXP_W: board, cell (r,c) at bits [(r·N+c)·EXP_W +: EXP_W], row 0 = top
- `score` out SCORE_W: accumulated score, saturating
- `busy` out 1: move in progress
- `gano` out 1: win flag
- `perdio` out 1: lose flag

## Operation
- FSM states: IDLE, CLEAR, SPAWN, WAIT, SHIFT, CHECK, EVAL, OVER.
- IDLE: wait for `start`. `start` in any state goes to CLEAR.
- CLEAR: zero the board, score, `gano` and `perdio`; latch `meta_exp`; set spawn count to 2.
- SPAWN: pointer starts at LFSR mod N·N and scans one cell per cycle with wrap. The first empty cell found gets exp 2 if LFSR[15:13]==3'b111, otherwise exp 1. If another spawn is pending, rescan; otherwise go to EVAL.
- WAIT: `move_ready`=1. A move is accepted when `move_valid`&&`move_ready`; latch `move_dir` and go to SHIFT.
- SHIFT: takes N cycles. Line i is read in the move direction, compressed, merged, and written back.
- Merge rules:
  - Left-to-right in the move direction, each tile merges at most once.
  - Equal nonzero pair e,e becomes e+1.
  - Tiles with exp = 2^EXP_W−1 never merge.
  - Each merge adds 2^(e+1) to `score`, which saturates at all-ones.
- CHECK: if any cell changed, go to SPAWN with 1 spawn pending; else go to WAIT (no spawn).
- EVAL:
  - `gano`=1 if any cell ≥ `meta_exp` and `meta_exp`≠0.
  - `perdio`=1 if there is no empty cell and no equal orthogonal neighbour pair.
  - If either flag is set, go to OVER; else go to WAIT.
- OVER: ignores moves; holds the board and flags until `start` or `rst`.
- `carga_valid` in IDLE/WAIT/OVER: copy `carga_tablero` into the board, keep score, go to EVAL (no spawn).
- `start` has priority over `carga_valid`, which has priority over `move_valid`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; free-running every cycle from reset.

## Timing
- Reset values:
  - board all 0, `score`=0, state IDLE
  - `move_ready`=0, `busy`=0, `gano`=0, `perdio`=0
  - LFSR=`LFSR_SEED`
- `start` at edge t: board zero at t+1; spawns take 1..N·N cycles each; EVAL; `move_ready` at the end.
- Move accepted at edge t: `move_ready` drops at t+1. SHIFT covers t+1..t+N, CHECK at t+N+1.
- No-change move: `move_ready` returns at t+N+2.
- `busy`=1 in SHIFT/CHECK/SPAWN/EVAL after a move.
- Outputs are registered; the board updates one line per SHIFT cycle.
- `rst` or `start` mid-SHIFT/SPAWN aborts the move immediately; partial lines are discarded by CLEAR/reset.

## Structure
- Package `movimiento_pkg`:
  - `dir_t` enum (ARRIBA, ABAJO, IZQ, DER)
  - `estado_t`
  - default parameters
- Sub-module `line_merge`, combinational:
  - input: N exponents
  - outputs: N merged exponents, score increment, changed flag
  - instantiated once and shared across SHIFT cycles.

## Test plan
- Reset, then `start` with meta 11: exactly two nonzero cells, each 1 or 2; `score`=0; flags 0; `move_ready`=1.
- Load row0={1,1,2,2}, other rows 0, then move left: row0={2,3,0,0}, one spawned tile elsewhere, `score`=12.
- Load row0={2,2,2,0}, move left: row0={3,2,0,0}. Load row0={2,2,3,0}, move left: row0={3,3,0,0} (no chained merge).
- Load row0 only = {1,2,3,4}, move up: board unchanged, no spawn, `move_ready` back after N+2 cycles.
- meta 11, load row0={10,10,0,0}, move left: cell(0,0)=11, `gano`=1, `move_ready` stays 0 through 3 further `move_valid` pulses.
- Load full checkerboard of exps 1/2: `perdio`=1. Then assert `rst` mid-SHIFT: all outputs return to reset values next cycle.
